// File: rtl/layer_pkg.sv
// Shared types for the layer streaming blocks: default word width, word and
// bank-pointer types, and the per-bank fill state.
package layer_pkg;

    localparam int WIDTH_DEF = 16;

    typedef logic signed [WIDTH_DEF-1:0] word_t;
    typedef logic                        bank_sel_t;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

endpackage

// File: rtl/collector_bank.sv
// One vector buffer of the collector: M words written one at a time by index,
// read out all at once as a flattened vector (element i at [i*WIDTH +: WIDTH]).
module collector_bank #(
    parameter int M     = 3,
    parameter int LOGM  = 2,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [LOGM-1:0]      wr_idx,
    input  logic [WIDTH-1:0]     wr_data,
    output logic [M*WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] words [M];

    // NOTE: this is a handful of flops, not a RAM macro, so clearing it on
    // reset is legitimate and keeps m_data defined before the first vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < M; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < M; g++) begin : g_flat
        assign rd_data[g*WIDTH +: WIDTH] = words[g];
    end

endmodule

// File: rtl/layer_stream_collector.sv
// Gathers M words from a layer's output stream into a vector (optional ReLU)
// and hands complete vectors out through a double-buffered wide handshake.
module layer_stream_collector
    import layer_pkg::*;
#(
    parameter int M     = 3,
    parameter int LOGM  = 2,
    parameter int WIDTH = WIDTH_DEF,
    parameter int RELU  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [M*WIDTH-1:0]   m_data,
    output logic [7:0]           vec_count
);

    bank_state_t          state_q [2];
    bank_state_t          state_d [2];
    logic [1:0]           full;
    bank_sel_t            wr_bank;
    bank_sel_t            rd_bank;
    logic [LOGM-1:0]      wr_cnt;
    logic                 in_accept;
    logic                 out_accept;
    logic                 last_word;
    logic [WIDTH-1:0]     wr_word;
    logic [1:0]           bank_wr_en;
    logic [M*WIDTH-1:0]   bank_data [2];

    assign full[0]    = (state_q[0] == BANK_FULL);
    assign full[1]    = (state_q[1] == BANK_FULL);

    // Ready depends only on registered state, so the producer never sees a
    // combinational path from its own valid back to its ready.
    assign s_ready    = reset && !full[wr_bank];
    assign in_accept  = s_valid && s_ready;
    assign last_word  = (wr_cnt == LOGM'(M - 1));
    assign wr_word    = ((RELU != 0) && data_in[WIDTH-1]) ? '0 : data_in;

    assign m_valid    = full[rd_bank];
    assign m_data     = bank_data[rd_bank];
    assign out_accept = m_valid && m_ready;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign bank_wr_en[g] = in_accept && (wr_bank == 1'(g));

        collector_bank #(
            .M     (M),
            .LOGM  (LOGM),
            .WIDTH (WIDTH)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (bank_wr_en[g]),
            .wr_idx  (wr_cnt),
            .wr_data (wr_word),
            .rd_data (bank_data[g])
        );
    end

    // Completion targets a non-full bank and drain targets a full one, so the
    // two updates below never hit the same bank in one cycle.
    always_comb begin
        // NOTE: every state_d entry gets its hold value first so no path
        // through this block leaves it unassigned and infers a latch.
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        for (int b = 0; b < 2; b++) begin
            if (in_accept && (wr_bank == 1'(b))) begin
                state_d[b] = last_word ? BANK_FULL : BANK_FILLING;
            end
            if (out_accept && (rd_bank == 1'(b))) begin
                state_d[b] = BANK_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            vec_count <= '0;
        end else begin
            if (in_accept) begin
                if (last_word) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + 1'b1;
                end
            end
            if (out_accept) begin
                rd_bank   <= ~rd_bank;
                vec_count <= vec_count + 8'd1;
            end
        end
    end

endmodule

// File: doc/layer_stream_collector.md
Name: layer_stream_collector

Overview:
- Receiving end of a layer's output stream: the `m_valid`/`m_ready`/`data_out` word stream of a `layer_*` block connects to this block's `s_*` side.
- Collects M consecutive signed words into one vector and applies optional ReLU per word.
- Presents each completed vector as a single wide word with its own valid/ready handshake.
- Double-buffered, so a layer streaming at full rate is never back-pressured while the consumer keeps up.

Parameters:
- M, 3: words per vector (= the producing layer's output rows).
- LOGM, 2: counter width; holds 0..M-1.
- WIDTH, 16: bits per word, two's complement.
- RELU, 1: 1 = negative words stored as 0; 0 = stored unchanged.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = in reset).
- s_valid  in  1  input word valid (from layer m_valid).
- s_ready  out  1  collector can accept a word (to layer m_ready).
- data_in  in  WIDTH  signed input word (from layer data_out).
- m_valid  out  1  completed vector available.
- m_ready  in  1  consumer accepts vector.
- m_data  out  M*WIDTH  vector; element 0 at bits [WIDTH-1:0], element i at [i*WIDTH +: WIDTH].
- vec_count  out  8  number of vectors delivered, wraps 255->0.

Behaviour:
- **Reset** (reset==0, asynchronous):
  - full[1:0]=0, wr_bank=0, rd_bank=0, wr_cnt=0, vec_count=0, all bank words=0.
  - Outputs: m_valid=0, s_ready=0 while in reset.
- **Input transfer:**
  - Acceptance = s_valid && s_ready at a rising edge.
  - s_ready = reset && !full[wr_bank] (combinational from registers only; no dependence on s_valid).
- **Storage:**
  - On acceptance, bank[wr_bank][wr_cnt] <= (RELU && data_in[WIDTH-1]) ? 0 : data_in.
  - Then wr_cnt increments.
- **Vector completion:**
  - Condition: acceptance with wr_cnt==M-1.
  - wr_cnt <= 0, full[wr_bank] <= 1, wr_bank toggles.
- **Per-bank state machine** (EMPTY / FILLING / FULL):
  - EMPTY->FILLING on first word; FILLING->FULL on word M-1; FULL->EMPTY on output acceptance.
- **Output side:**
  - m_valid = full[rd_bank], a registered flag.
  - m_data = bank[rd_bank] via combinational mux.
  - Output acceptance = m_valid && m_ready: full[rd_bank] <= 0, rd_bank toggles, vec_count increments.
- **Latency:** last word accepted at edge k -> m_valid=1 in the cycle after edge k. Minimum input-to-output latency is 1 cycle after the final word.
- **Stability:** while m_valid && !m_ready, m_data and m_valid must hold. The displayed bank is FULL and therefore never written.
- **Simultaneous events:**
  - Completion on wr_bank and output acceptance on rd_bank in the same edge are both applied.
  - They cannot target the same bank: set requires full=0, clear requires full=1.
- **Both banks full:** s_ready=0. It re-asserts in the cycle after output acceptance frees rd_bank. The held s_valid word is accepted then, with no loss or duplication.
- **Throughput:** with s_valid=1 and m_ready=1 continuously, one vector per M cycles and no s_ready bubbles.
- **Reset mid-vector:** partial vector discarded; the first word after release is element 0.
- **m_data when m_valid=0:** shows bank[rd_bank] contents (defined, not X); the consumer must ignore it.
- **Arithmetic:** ReLU is the only arithmetic; no saturation or width change.

Decomposition:
- Shared package `layer_pkg`: WIDTH_DEF=16, typedef `word_t` = logic signed [15:0], typedef `bank_sel_t` = logic (one bit).
- Sub-module `collector_bank` (one instance per bank):
  - Contents: M x WIDTH register array, asynchronous active-low clear, write enable, write index, flattened read output.
- Parent module holds: the counters, full flags, bank pointers and handshake logic.

Test Plan:
1. M=3, RELU=1, m_ready=1; send 5, -7, 300 on consecutive cycles -> m_valid=1 one cycle after 3rd acceptance for exactly one cycle; m_data={16'd300,16'd0,16'd5}; vec_count=1.
2. m_ready=0; stream 7 words (1..7) -> s_ready falls after word 6, word 7 held. Raise m_ready for one cycle -> m_data={3,2,1} delivered; s_ready=1 next cycle; word 7 accepted; next vector after the two following words.
3. s_valid=1 and m_ready=1 continuously for 12 words (values 0..11) -> 4 vectors, s_ready never low, one m_valid pulse every 3 cycles; vec_count=4.
4. Send -40, -105, then drive reset=0 asynchronously mid-cycle -> m_valid=0 and s_ready=0 immediately. After release send 1, 2, 3 -> m_data={3,2,1}; vec_count=1.
5. RELU=0; send -1, -105, -40 -> m_data={16'hFFD8,16'hFF97,16'hFFFF}.
6. m_ready toggling every cycle with random s_valid gaps over 50 vectors -> scoreboard matches every vector in order; m_data stable whenever m_valid && !m_ready.
